// File: rtl/rgb2gray_pipe.sv
`timescale 1ns/1ps
// rgb2gray_pipe: three-stage RGB to grayscale converter for the camera-to-LCD
// pixel stream. The luma weighting mode is selectable at runtime, but a new
// mode is only adopted on the first valid pixel of a frame, at (0,0).
// Stage 1 registers the inputs, stage 2 multiplies by the coefficients and
// stage 3 sums, rounds, scales and saturates.
// Optional feature macro: RGB2GRAY_THRESH_EN adds a per-frame binary
// threshold output (iThresh / oBinary).
// OUT_W must lie in 1..IN_W.
module rgb2gray_pipe #(
  parameter int         IN_W         = 12,
  parameter int         OUT_W        = 8,
  parameter int         COORD_W      = 16,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic               iCLK,
  input  logic               iReset_n,
  input  logic [IN_W-1:0]    iRed,
  input  logic [IN_W-1:0]    iGreen,
  input  logic [IN_W-1:0]    iBlue,
  input  logic               iDval,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [1:0]         iMode,
`ifdef RGB2GRAY_THRESH_EN
  input  logic [OUT_W-1:0]   iThresh,
  output logic               oBinary,
`endif
  output logic [OUT_W-1:0]   oGray,
  output logic [COORD_W-1:0] oX_Cont,
  output logic [COORD_W-1:0] oY_Cont,
  output logic               oDval,
  output logic [1:0]         oMode
);

  // Coefficients carry 8 fractional bits and sum to 256 in every mode, so the
  // weighted sum never exceeds (2^IN_W-1)*256.
  localparam int SH     = 8 + IN_W - OUT_W;
  localparam int PROD_W = IN_W + 9;
  // Two bits of headroom over IN_W+8: covers the full-scale sum plus the
  // rounding constant with margin.
  localparam int SUM_W  = IN_W + 10;
  // Width left after the scaling shift; always OUT_W+2, so the saturation
  // test below always has guard bits to inspect.
  localparam int GRAY_W = SUM_W - SH;
  localparam logic [SUM_W-1:0] ROUND = SUM_W'(1) << (SH - 1);

  // Coefficient lookup: idx 0 = red, 1 = green, 2 = blue.
  function automatic logic [8:0] coef_of(input logic [1:0] m, input int idx);
    logic [8:0] c;
    c = 9'd0;
    case (m)
      2'd0: c = (idx == 0) ? 9'd77 : (idx == 1) ? 9'd150 : 9'd29;   // BT.601
      2'd1: c = (idx == 0) ? 9'd54 : (idx == 1) ? 9'd183 : 9'd19;   // BT.709
      2'd2: c = (idx == 1) ? 9'd86 : 9'd85;                         // average
      default: c = (idx == 1) ? 9'd256 : 9'd0;                      // green only
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // Frame-start mode latch
  // ---------------------------------------------------------------------
  logic       frame_start;
  logic [1:0] mode_reg;
  logic [1:0] eff_mode;

  // Only a valid pixel at (0,0) opens a frame; invalid samples never count.
  assign frame_start = iDval && (iX_Cont == '0) && (iY_Cont == '0);
  // The frame-start pixel itself already uses the newly requested mode.
  assign eff_mode    = frame_start ? iMode : mode_reg;

  // Active mode register: reloaded on every frame start, held otherwise.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      mode_reg <= DEFAULT_MODE;
    end else if (frame_start) begin
      mode_reg <= iMode;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: input registers
  // ---------------------------------------------------------------------
  logic [3*IN_W-1:0]  comp_in;
  logic [3*IN_W-1:0]  comp1;
  logic               dval1;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [1:0]         mode1;

  assign comp_in = {iBlue, iGreen, iRed};

  // Capture the pixel, its coordinates and the mode it will be converted with.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      comp1 <= '0;
      dval1 <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      mode1 <= DEFAULT_MODE;
    end else begin
      comp1 <= comp_in;
      dval1 <= iDval;
      x1    <= iX_Cont;
      y1    <= iY_Cont;
      mode1 <= eff_mode;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: per-component products
  // ---------------------------------------------------------------------
  logic [3*PROD_W-1:0] prod_c;
  logic [3*PROD_W-1:0] prod2;
  logic                dval2;
  logic [COORD_W-1:0]  x2;
  logic [COORD_W-1:0]  y2;
  logic [1:0]          mode2;

  // One multiplier per colour component.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mult
      assign prod_c[gi*PROD_W +: PROD_W] =
        PROD_W'(comp1[gi*IN_W +: IN_W]) * PROD_W'(coef_of(mode1, gi));
    end
  endgenerate

  // Register the products alongside the delayed side-band signals.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      prod2 <= '0;
      dval2 <= 1'b0;
      x2    <= '0;
      y2    <= '0;
      mode2 <= DEFAULT_MODE;
    end else begin
      prod2 <= prod_c;
      dval2 <= dval1;
      x2    <= x1;
      y2    <= y1;
      mode2 <= mode1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: sum, round, scale, saturate
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0]  sum_c;
  logic [GRAY_W-1:0] scaled_c;
  logic [OUT_W-1:0]  gray_c;

  assign sum_c    = SUM_W'(prod2[0*PROD_W +: PROD_W])
                  + SUM_W'(prod2[1*PROD_W +: PROD_W])
                  + SUM_W'(prod2[2*PROD_W +: PROD_W])
                  + ROUND;
  assign scaled_c = sum_c[SUM_W-1:SH];
  // Rounding a full-scale input can land exactly on 2^OUT_W; clamp instead
  // of letting it wrap to zero.
  assign gray_c   = (|scaled_c[GRAY_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                : scaled_c[OUT_W-1:0];

  // Output registers, aligned three cycles after the input.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      oGray   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
      oDval   <= 1'b0;
      oMode   <= DEFAULT_MODE;
    end else begin
      oGray   <= gray_c;
      oX_Cont <= x2;
      oY_Cont <= y2;
      oDval   <= dval2;
      oMode   <= mode2;
    end
  end

`ifdef RGB2GRAY_THRESH_EN
  // ---------------------------------------------------------------------
  // Optional binary threshold, latched per frame like the mode
  // ---------------------------------------------------------------------
  localparam logic [OUT_W-1:0] THR_RST = OUT_W'(1) << (OUT_W - 1);

  logic [OUT_W-1:0] thresh_reg;
  logic [OUT_W-1:0] eff_thresh;
  logic [OUT_W-1:0] thr1;
  logic [OUT_W-1:0] thr2;

  assign eff_thresh = frame_start ? iThresh : thresh_reg;

  // Active threshold register: same frame-start rule as the mode.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      thresh_reg <= THR_RST;
    end else if (frame_start) begin
      thresh_reg <= iThresh;
    end
  end

  // Carry the threshold down the pipe so each pixel compares against the
  // value that was active when it entered. Reset to the default threshold so
  // the flushed pipe cannot report a spurious binary 1.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      thr1    <= THR_RST;
      thr2    <= THR_RST;
      oBinary <= 1'b0;
    end else begin
      thr1    <= eff_thresh;
      thr2    <= thr1;
      oBinary <= (gray_c >= thr2);
    end
  end
`endif

endmodule

// File: tb/tb_rgb2gray_pipe.sv
`timescale 1ns/1ps
// tb_rgb2gray_pipe: table-driven vectors plus hand-written sequences.
// Expected outputs are queued when the stimulus is driven and popped when
// the DUT presents the corresponding output three clock edges later.
module tb_rgb2gray_pipe;

  localparam int         IN_W     = 12;
  localparam int         OUT_W    = 8;
  localparam int         COORD_W  = 16;
  localparam logic [1:0] DEF_MODE = 2'd0;
  localparam int         SH       = 8 + IN_W - OUT_W;
  localparam logic [OUT_W-1:0] THR_DEF = 8'd128;

  logic               iCLK = 1'b0;
  logic               iReset_n;
  logic [IN_W-1:0]    iRed, iGreen, iBlue;
  logic               iDval;
  logic [COORD_W-1:0] iX_Cont, iY_Cont;
  logic [1:0]         iMode;
  logic [OUT_W-1:0]   oGray;
  logic [COORD_W-1:0] oX_Cont, oY_Cont;
  logic               oDval;
  logic [1:0]         oMode;
`ifdef RGB2GRAY_THRESH_EN
  logic [OUT_W-1:0]   iThresh;
  logic               oBinary;
`endif

  always #5 iCLK = ~iCLK;

`ifdef RGB2GRAY_THRESH_EN
  rgb2gray_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .COORD_W(COORD_W), .DEFAULT_MODE(DEF_MODE)) dut (
    .iCLK(iCLK), .iReset_n(iReset_n), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iDval(iDval), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iMode(iMode),
    .iThresh(iThresh), .oBinary(oBinary),
    .oGray(oGray), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oDval(oDval), .oMode(oMode));
`else
  rgb2gray_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .COORD_W(COORD_W), .DEFAULT_MODE(DEF_MODE)) dut (
    .iCLK(iCLK), .iReset_n(iReset_n), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iDval(iDval), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iMode(iMode),
    .oGray(oGray), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oDval(oDval), .oMode(oMode));
`endif

  typedef struct {
    logic               dv;
    logic [OUT_W-1:0]   gray;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         mode;
    logic               bin;
  } exp_t;

  typedef struct {
    logic [IN_W-1:0]    r, g, b;
    logic               dv;
    logic [COORD_W-1:0] x, y;
    logic [1:0]         m;
    logic [OUT_W-1:0]   eg;
    logic [1:0]         em;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: active mode and threshold.
  logic [1:0]       m_act;
  logic [OUT_W-1:0] thr_in;
  logic [OUT_W-1:0] thr_act;

  function automatic vec_t mk(input int r, input int g, input int b, input int dv,
                              input int x, input int y, input int m, input int eg, input int em);
    vec_t v;
    v.r = IN_W'(r); v.g = IN_W'(g); v.b = IN_W'(b); v.dv = dv[0];
    v.x = COORD_W'(x); v.y = COORD_W'(y); v.m = m[1:0];
    v.eg = OUT_W'(eg); v.em = em[1:0];
    return v;
  endfunction

  // Independent arithmetic model of the luma conversion.
  function automatic logic [OUT_W-1:0] model_gray(input logic [IN_W-1:0] r, input logic [IN_W-1:0] g,
                                                  input logic [IN_W-1:0] b, input logic [1:0] m);
    longint cr, cg, cb, s;
    case (m)
      2'd0:    begin cr = 77; cg = 150; cb = 29; end
      2'd1:    begin cr = 54; cg = 183; cb = 19; end
      2'd2:    begin cr = 85; cg = 86;  cb = 85; end
      default: begin cr = 0;  cg = 256; cb = 0;  end
    endcase
    s = longint'(r) * cr + longint'(g) * cg + longint'(b) * cb;
    s = (s + (longint'(1) << (SH - 1))) >> SH;
    if (s > (longint'(1) << OUT_W) - 1) s = (longint'(1) << OUT_W) - 1;
    return OUT_W'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check("oDval", 32'(oDval), 32'(e.dv));
    check("oGray", 32'(oGray), 32'(e.gray));
    check("oX_Cont", 32'(oX_Cont), 32'(e.x));
    check("oY_Cont", 32'(oY_Cont), 32'(e.y));
    check("oMode", 32'(oMode), 32'(e.mode));
`ifdef RGB2GRAY_THRESH_EN
    check("oBinary", 32'(oBinary), 32'(e.bin));
`endif
    if (e.dv)
      $display("pixel out x=%0d y=%0d gray=%0d mode=%0d", oX_Cont, oY_Cont, oGray, oMode);
  endtask

  // After reset the pipe holds two cycles of cleared state ahead of the first new pixel.
  task automatic push_reset_state();
    exp_t e;
    e.dv = 1'b0; e.gray = '0; e.x = '0; e.y = '0; e.mode = DEF_MODE; e.bin = 1'b0;
    sb.delete();
    sb.push_back(e);
    sb.push_back(e);
    m_act   = DEF_MODE;
    thr_act = THR_DEF;
  endtask

  // Drive one sample with an explicit expectation, then advance one clock.
  task automatic drive(input logic [IN_W-1:0] r, input logic [IN_W-1:0] g, input logic [IN_W-1:0] b,
                       input logic dv, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                       input logic [1:0] m, input logic [OUT_W-1:0] eg, input logic [1:0] em);
    exp_t e;
    iRed = r; iGreen = g; iBlue = b; iDval = dv; iX_Cont = x; iY_Cont = y; iMode = m;
`ifdef RGB2GRAY_THRESH_EN
    iThresh = thr_in;
`endif
    if (dv && x == '0 && y == '0) begin
      m_act   = m;
      thr_act = thr_in;
    end
    e.dv = dv; e.gray = eg; e.x = x; e.y = y; e.mode = em; e.bin = (eg >= thr_act);
    sb.push_back(e);
    @(posedge iCLK);
    #1;
    if (sb.size() == 3) compare_out();
  endtask

  // Drive one sample whose expectation comes from the reference model.
  task automatic drive_m(input logic [IN_W-1:0] r, input logic [IN_W-1:0] g, input logic [IN_W-1:0] b,
                         input logic dv, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                         input logic [1:0] m);
    logic [1:0] em;
    em = (dv && x == '0 && y == '0) ? m : m_act;
    drive(r, g, b, dv, x, y, m, model_gray(r, g, b, em), em);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Corner-case vectors: saturation, mode latch, bypass, invalid frame start.
    vt[0] = mk(4095, 0,    0,    1, 0, 0, 0, 77,  0);
    vt[1] = mk(4095, 4095, 4095, 1, 1, 0, 0, 255, 0);
    vt[2] = mk(1200, 1200, 1200, 1, 0, 0, 2, 75,  2);
    vt[3] = mk(0,    2048, 0,    1, 0, 0, 3, 128, 3);
    vt[4] = mk(0,    4095, 0,    1, 0, 0, 0, 150, 0);
    vt[5] = mk(0,    4095, 0,    1, 1, 0, 1, 150, 0);
    vt[6] = mk(0,    4095, 0,    1, 2, 0, 1, 150, 0);
    vt[7] = mk(0,    4095, 0,    1, 0, 0, 1, 183, 1);
    vt[8] = mk(0,    4095, 0,    0, 0, 0, 3, 183, 1);
    vt[9] = mk(0,    4095, 0,    1, 5, 0, 3, 183, 1);

    iReset_n = 1'b0;
    iRed = '0; iGreen = '0; iBlue = '0; iDval = 1'b0;
    iX_Cont = '0; iY_Cont = '0; iMode = 2'd2;
    thr_in = THR_DEF;
`ifdef RGB2GRAY_THRESH_EN
    iThresh = THR_DEF;
`endif
    repeat (2) @(posedge iCLK);
    #1;
    check("reset oDval", 32'(oDval), 32'd0);
    check("reset oGray", 32'(oGray), 32'd0);
    check("reset oMode", 32'(oMode), 32'(DEF_MODE));
    iReset_n = 1'b1;
    push_reset_state();

    for (int i = 0; i < 10; i++)
      drive(vt[i].r, vt[i].g, vt[i].b, vt[i].dv, vt[i].x, vt[i].y, vt[i].m, vt[i].eg, vt[i].em);
    for (int i = 0; i < 3; i++) drive_m('0, '0, '0, 1'b0, 16'd40, 16'd40, 2'd0);

    // Continuous run of ten valid pixels on one line.
    for (int i = 0; i < 10; i++)
      drive_m(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), 1'b1, COORD_W'(i), 16'd3, 2'd2);

    // Mixed stream with random gaps, modes and periodic frame starts.
    for (int i = 0; i < 24; i++)
      drive_m(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), 1'($urandom_range(0, 3) != 0),
              COORD_W'(i % 6), COORD_W'((i % 12) < 6 ? 0 : 1), 2'($urandom));

    for (int i = 1; i < 5; i++)
      drive_m(12'd3000, 12'd1000, 12'd500, 1'b1, COORD_W'(i), 16'd2, 2'd0);

    // Reset pulse between clock edges: outputs must clear immediately.
    #1 iReset_n = 1'b0;
    #1;
    check("async oDval", 32'(oDval), 32'd0);
    check("async oGray", 32'(oGray), 32'd0);
    check("async oX_Cont", 32'(oX_Cont), 32'd0);
    check("async oY_Cont", 32'(oY_Cont), 32'd0);
    check("async oMode", 32'(oMode), 32'(DEF_MODE));
    @(posedge iCLK);
    #1 iReset_n = 1'b1;
    push_reset_state();

    // Resume: new frame in mode 3 with threshold 100 (gray 100 and 99).
    thr_in = 8'd100;
    drive_m('0, 12'd1600, '0, 1'b1, 16'd0, 16'd0, 2'd3);
    thr_in = 8'd7;
    drive_m('0, 12'd1584, '0, 1'b1, 16'd1, 16'd0, 2'd1);
    drive_m('0, 12'd1600, '0, 1'b1, 16'd2, 16'd0, 2'd0);
    for (int i = 0; i < 3; i++) drive_m('0, '0, '0, 1'b0, 16'd9, 16'd9, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
Parametrised colour-to-grayscale converter for the camera-to-LCD pixel stream. It takes per-pixel RGB with valid and X/Y coordinates, and applies a runtime-selectable luma weighting (BT.601, BT.709, average, green-only) in fixed point. The result is rounded and saturated to the output width. Coordinates and valid are delayed to stay aligned with the gray output. Mode changes take effect only at frame start, so a frame is never converted with mixed weights.

Parameters:
IN_W, 12, input colour component width
OUT_W, 8, gray output width; must satisfy 1 <= OUT_W <= IN_W
COORD_W, 16, X/Y coordinate width
DEFAULT_MODE, 0, active mode after reset (0..3)

Ports:
iCLK  in  1  clock
iReset_n  in  1  asynchronous active-low reset
iRed  in  IN_W  red component
iGreen  in  IN_W  green component
iBlue  in  IN_W  blue component
iDval  in  1  input pixel valid
iX_Cont  in  COORD_W  input X coordinate
iY_Cont  in  COORD_W  input Y coordinate
iMode  in  2  requested weighting mode
oGray  out  OUT_W  gray value
oX_Cont  out  COORD_W  X aligned to oGray
oY_Cont  out  COORD_W  Y aligned to oGray
oDval  out  1  output valid
oMode  out  2  mode used for the pixel currently on oGray

Behaviour:
- Reset: iReset_n is asynchronous, active-low; clock is iCLK. All pipeline registers clear to 0, including oGray, oX_Cont, oY_Cont and oDval. Active mode register and oMode reset to DEFAULT_MODE.
- Streaming pipeline with no backpressure. Every cycle advances. Latency is exactly 3 cycles from input to output for data, valid, coordinates and mode.
- Stage 1: register R, G, B, iDval, X, Y and the effective mode.
- Stage 2: three products, each component x 9-bit coefficient, width IN_W+9.
- Stage 3: sum, round, scale and saturate; register outputs.
- Coefficients (fractional bits = 8, each mode's coefficients sum to 256):
  - mode 0 (BT.601): R 77, G 150, B 29
  - mode 1 (BT.709): R 54, G 183, B 19
  - mode 2 (average): R 85, G 86, B 85
  - mode 3 (green): R 0, G 256, B 0
- Scaling: SH = 8 + IN_W - OUT_W; gray = (sum + 2^(SH-1)) >> SH. If the result >= 2^OUT_W, saturate to 2^OUT_W-1. Sum width must hold (2^IN_W-1)*256 + 2^(SH-1) without overflow.
- Frame-start mode latch: the frame-start condition is iDval=1 and iX_Cont=0 and iY_Cont=0.
  - On frame start, iMode is loaded into the active mode register, and that same pixel already uses the new iMode (bypass).
  - On every other pixel the active mode register holds; iMode changes mid-frame are ignored until the next frame start.
  - Samples with iDval=0 never update the mode.
- Invalid samples (iDval=0) still propagate through data and coordinates; only oDval marks validity. Downstream must ignore oGray when oDval=0.
- Back-to-back frame starts (two consecutive (0,0) valid pixels) each reload the mode.
- Reset mid-stream: in-flight pixels are discarded. oDval is 0 until 3 cycles after the first valid input following reset release.

Optional Feature:
RGB2GRAY_THRESH_EN
- Defined: adds input iThresh [OUT_W] and output oBinary [1].
  - iThresh is latched with the same frame-start rule as iMode; reset value 2^(OUT_W-1).
  - oBinary = 1 when the final saturated gray >= latched threshold. It is registered in stage 3, aligned with oGray, and resets to 0.
- Undefined: iThresh and oBinary do not exist; no threshold logic.

Test Plan:
- Defaults (IN_W=12, OUT_W=8), mode 0, one valid pixel R=4095 G=0 B=0 at (0,0) -> 3 cycles later oDval=1, oGray=77, oX/oY=0, oMode=0.
- Saturation: mode 0, R=G=B=4095 -> oGray=255, not 0. Mode 2, R=G=B=1200 -> oGray=75. Mode 3, G=2048 -> oGray=128.
- Mode latch: hold iMode=1 during a frame starting in mode 0, with pixels at (1,0) G=4095 -> oGray=150, oMode=0. Next valid (0,0) with G=4095 -> oGray=183, oMode=1.
- Invalid (0,0) with iDval=0 while iMode=3 -> active mode unchanged. A following valid (5,0) pixel still uses the old mode.
- Continuous stream of 10 valid pixels with X=0..9 -> 10 consecutive oDval=1 cycles, oX_Cont=0..9 in order, each exactly 3 cycles after input.
- Assert iReset_n low for 1 cycle mid-stream -> outputs go 0 asynchronously and oMode=DEFAULT_MODE. The stream resumes with correct 3-cycle latency. With RGB2GRAY_THRESH_EN and iThresh=100 latched: gray 100 -> oBinary=1, gray 99 -> oBinary=0.
